// File: rtl/spi_slave_regs.sv
// SPI responder with a 16 x 8 register file, all CPOL/CPHA modes, pins oversampled on clk.
// Optional SPI_ECHO_EN: write-data bytes echo the previously received byte on miso.
`timescale 1ns/1ps
module spi_slave_regs #(
  parameter int unsigned NREG        = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STAT_BYTE   = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          sclk,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] hrd_addr,
  output logic [7:0]    hrd_data,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                   lead_e, trail_e, active, sample_e, shift_e, byte_done;

  logic [2:0]    cnt;
  logic [7:0]    rx_sr, tx_sr, next_byte, nb_d, rx_byte, echo_byte;
  logic          load_pend, got_byte;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [NREG];

  // ss_n synchronizer resets high so miso stays undriven through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign lead_e    = cpol ? sclk_fall : sclk_rise;
  assign trail_e   = cpol ? sclk_rise : sclk_fall;
  assign active    = ~ss_s && (state_q != IDLE);
  assign sample_e  = active && (cpha ? trail_e : lead_e);
  assign shift_e   = active && (cpha ? lead_e : trail_e);
  assign byte_done = sample_e && (cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], mosi_s};

`ifdef SPI_ECHO_EN
  assign echo_byte = rx_byte;
`else
  assign echo_byte = 8'h00;
`endif

  always_comb begin
    nb_d = echo_byte;
    case (state_q)
      CMD:     if (rx_byte[7]) nb_d = regs[rx_byte[AW-1:0]];
      RDATA:   nb_d = regs[ptr + AW'(1)];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (byte_done) state_d = rx_byte[7] ? RDATA : WDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      next_byte  <= '0;
      load_pend  <= 1'b0;
      got_byte   <= 1'b0;
      ptr        <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      regs       <= '{default: '0};
    end else begin
      wr_stb     <= 1'b0;
      frame_done <= 1'b0;
      if (ss_rise) begin
        // a partial byte is simply dropped: no write, no pointer step
        frame_done <= got_byte;
        got_byte   <= 1'b0;
      end else if (state_q == IDLE) begin
        if (ss_fall) begin
          cnt       <= '0;
          tx_sr     <= STAT_BYTE;
          next_byte <= STAT_BYTE;
          load_pend <= 1'b0;
          got_byte  <= 1'b0;
        end
      end else begin
        if (sample_e) begin
          rx_sr <= rx_byte;
          cnt   <= cnt + 3'd1;
          if (byte_done) begin
            got_byte  <= 1'b1;
            load_pend <= 1'b1;
            next_byte <= nb_d;
            case (state_q)
              CMD:   ptr <= rx_byte[AW-1:0];
              WDATA: begin
                regs[ptr] <= rx_byte;
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + AW'(1);
              end
              RDATA: ptr <= ptr + AW'(1);
              default: ;
            endcase
          end
        end
        // cpha=1 reloads on the first leading edge of a byte, cpha=0 on the trailing edge after completion
        if (shift_e) begin
          if (cpha ? (cnt == 3'd0) : load_pend) tx_sr <= next_byte;
          else                                  tx_sr <= {tx_sr[6:0], 1'b0};
          load_pend <= 1'b0;
        end
      end
    end
  end

  assign miso_oe  = ~ss_s;
  assign miso     = miso_oe & tx_sr[7];
  assign hrd_data = regs[hrd_addr];

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: bit-banged SPI master plus write/miso scoreboards.
`timescale 1ns/1ps
module tb_spi_slave_regs;

  localparam int HALF = 500;  // sclk half period = 50 clk cycles
`ifdef SPI_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, wr_stb, frame_done;
  logic [3:0] wr_addr, hrd_addr = '0;
  logic [7:0] wr_data, hrd_data;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_miso [$];

  spi_slave_regs #(.NREG(16), .AW(4), .SYNC_STAGES(2), .STAT_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .hrd_addr(hrd_addr),
    .hrd_data(hrd_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // write scoreboard: every wr_stb pops one expected {addr, data}
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (wr_stb) begin
      n_assert++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic spi_frame(input logic m_cpol, input logic m_cpha, input int nbits, input bit keep_low);
    int b, k, nb, nk;
    cpol = m_cpol;
    cpha = m_cpha;
    sclk = m_cpol;
    for (int i = 0; i < 8; i++) rx_buf[i] = 8'hxx;
    repeat (20) @(posedge clk);
    #2;
    ss_n = 1'b0;
    if (!m_cpha) mosi = tx_buf[0][7];
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = i / 8;
      k = 7 - (i % 8);
      sclk = ~sclk;
      if (m_cpha) mosi = tx_buf[b][k];
      else        rx_buf[b][k] = miso;
      #HALF;
      sclk = ~sclk;
      if (m_cpha) rx_buf[b][k] = miso;
      else if (i + 1 < nbits) begin
        nb = (i + 1) / 8;
        nk = 7 - ((i + 1) % 8);
        mosi = tx_buf[nb][nk];
      end
      #HALF;
    end
    if (!keep_low) begin
      ss_n = 1'b1;
      repeat (20) @(posedge clk);
    end
  endtask

  task automatic check_frame(input string name, input int nbytes, input int fd_before);
    logic [7:0] e;
    for (int i = 0; i < nbytes; i++) begin
      e = exp_miso.pop_front();
      n_assert++;
      if (rx_buf[i] !== e) begin
        n_fail++;
        $display("FAIL %s_miso%0d: got %h, required %h", name, i, rx_buf[i], e);
      end
    end
    n_assert++;
    if (exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, exp_wr.size());
      exp_wr.delete();
    end
    n_assert++;
    if (fd_cnt - fd_before != 1) begin
      n_fail++;
      $display("FAIL %s_frame_done: got %0d pulses, required 1", name, fd_cnt - fd_before);
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] v);
    hrd_addr = a;
    #1;
    n_assert++;
    if (hrd_data !== v) begin
      n_fail++;
      $display("FAIL %s_reg%0d: got %h, required %h", name, a, hrd_data, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_assert++;
    if ({miso, miso_oe, wr_stb, frame_done, wr_addr, wr_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got miso=%b oe=%b stb=%b fd=%b addr=%h data=%h, required all 0",
               miso, miso_oe, wr_stb, frame_done, wr_addr, wr_data);
    end
    check_reg("reset", 4'd0, 8'h00);
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_mode0_write();
    int f0 = fd_cnt;
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h93; tx_buf[2] = 8'h8A;
    exp_wr.push_back({4'd3, 8'h93});
    exp_wr.push_back({4'd4, 8'h8A});
    exp_miso.push_back(8'hA5);
    exp_miso.push_back(ECHO ? 8'h03 : 8'h00);
    exp_miso.push_back(ECHO ? 8'h93 : 8'h00);
    spi_frame(1'b0, 1'b0, 24, 1'b0);
    check_frame("m0_write", 3, f0);
    check_reg("m0_write", 4'd3, 8'h93);
    check_reg("m0_write", 4'd4, 8'h8A);
  endtask

  task automatic test_mode3_read();
    int f0 = fd_cnt;
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    exp_miso.push_back(8'hA5);
    exp_miso.push_back(8'h93);
    exp_miso.push_back(8'h8A);
    spi_frame(1'b1, 1'b1, 24, 1'b0);
    check_frame("m3_read", 3, f0);
    check_reg("m3_read", 4'd4, 8'h8A);
  endtask

  task automatic test_wrap();
    int f0 = fd_cnt;
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    exp_wr.push_back({4'd15, 8'h11});
    exp_wr.push_back({4'd0, 8'h22});
    exp_miso.push_back(8'hA5);
    exp_miso.push_back(ECHO ? 8'h0F : 8'h00);
    exp_miso.push_back(ECHO ? 8'h11 : 8'h00);
    spi_frame(1'b0, 1'b1, 24, 1'b0);
    check_frame("wrap", 3, f0);
    check_reg("wrap", 4'd15, 8'h11);
    check_reg("wrap", 4'd0, 8'h22);
  endtask

  task automatic test_abort();
    int f0 = fd_cnt;
    tx_buf[0] = 8'h07; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h00;
    exp_miso.push_back(8'hA5);
    spi_frame(1'b1, 1'b0, 13, 1'b0);
    check_frame("abort", 1, f0);
    check_reg("abort", 4'd7, 8'h00);
  endtask

  task automatic test_back_to_back_echo();
    int f0 = fd_cnt;
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h5A; tx_buf[2] = 8'hC3;
    exp_wr.push_back({4'd5, 8'h5A});
    exp_wr.push_back({4'd6, 8'hC3});
    exp_miso.push_back(8'hA5);
    exp_miso.push_back(ECHO ? 8'h05 : 8'h00);
    exp_miso.push_back(ECHO ? 8'h5A : 8'h00);
    spi_frame(1'b0, 1'b0, 24, 1'b0);
    check_frame("echo", 3, f0);
    check_reg("echo", 4'd6, 8'hC3);
  endtask

  task automatic test_reset_mid_read();
    int f0;
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_frame(1'b0, 1'b0, 12, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_oe: got %b, required 0", miso_oe);
    end
    ss_n = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    for (int a = 0; a < 16; a++) check_reg("midreset", 4'(a), 8'h00);
    f0 = fd_cnt;
    exp_miso.push_back(8'hA5);
    exp_miso.push_back(8'h00);
    spi_frame(1'b0, 1'b0, 16, 1'b0);
    check_frame("post_reset_read", 2, f0);
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_mode3_read();
    test_wrap();
    test_abort();
    test_back_to_back_echo();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
